// File: rtl/s_rca_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : s_rca_pipe_pkg
// Description : Shared types, default sizing and configuration helpers for
//               the pipelined signed ripple-carry adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package s_rca_pipe_pkg;

  localparam int DEF_WIDTH  = 24;
  localparam int DEF_STAGES = 4;

  // Per-stage control record; the data part (lower sum bits and the
  // not-yet-rippled a/b' bits) shrinks/grows per stage and lives beside it.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  // Bits handled by one ripple segment.
  function automatic int seg_width(input int width, input int stages);
    return (stages < 1) ? width : width / stages;
  endfunction

  // Legal sizing: at least two bits, at least one stage, equal segments.
  function automatic bit cfg_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/s_rca_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : s_rca_pipe_if
// Description : Operand stream in, result stream out, both valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface s_rca_pipe_if
  import s_rca_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic             out_ovf;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  // The adder pipeline itself.
  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface
`default_nettype wire

// File: rtl/fa.sv
`default_nettype none
// ============================================================================
// Module      : fa
// Description : One-bit full adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule
`default_nettype wire

// File: rtl/s_rca_pipe_rca_seg.sv
`default_nettype none
// ============================================================================
// Module      : rca_seg
// Description : Combinational SEG_W-bit ripple chain of full adders with
//               carry in and carry out.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_seg #(
  parameter int SEG_W = 6
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] s,
  output logic             cout
);
  logic [SEG_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SEG_W; i++) begin : g_bit
    fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[SEG_W];
endmodule
`default_nettype wire

// File: rtl/s_rca_pipe.sv
`default_nettype none
// ============================================================================
// Module      : s_rca_pipe
// Description : Pipelined signed ripple-carry adder/subtractor. WIDTH bits
//               split into STAGES equal segments with registered carries;
//               one beat per cycle, global stall, exact WIDTH+1 result and
//               overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module s_rca_pipe
  import s_rca_pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic       clk,
  input  logic       rst_n,
  s_rca_pipe_if.slave bus
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("s_rca_pipe: WIDTH must be >= 2 and divisible by STAGES >= 1");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH:0]   out_sum_d,   out_sum_q;
  logic             out_ovf_d,   out_ovf_q;

  // Whole pipe moves together whenever the output slot is empty or drained;
  // subtraction is a + ~b + 1 with the +1 entering as stage-0 carry.
  always_comb begin
    advance = ~out_valid_q | bus.out_ready;
    b_eff   = bus.in_sub ? ~bus.in_b : bus.in_b;
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;

  // --------------------------------------------------------------------------
  // Intermediate stages 0..STAGES-2. Stage k ripples bits [LO +: SEG] and
  // keeps: the HI finished sum bits, the carry out, and the REM upper a/b'
  // bits that later stages still need.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < STAGES - 1; k++) begin : g_mid
    localparam int LO  = k * SEG;
    localparam int HI  = LO + SEG;
    localparam int REM = WIDTH - HI;

    logic                valid_src;
    logic                carry_src;
    logic [WIDTH-LO-1:0] a_src;
    logic [WIDTH-LO-1:0] b_src;
    logic [HI-1:0]       sum_new;

    logic [SEG-1:0]      seg_sum;
    logic                seg_cout;

    stage_ctl_t          ctl_d, ctl_q;
    logic [HI-1:0]       sum_d, sum_q;
    logic [REM-1:0]      a_d, a_q;
    logic [REM-1:0]      b_d, b_q;

    if (k == 0) begin : g_src_in
      // First stage takes operands straight from the input port.
      always_comb begin
        valid_src = bus.in_valid;
        carry_src = bus.in_sub;
        a_src     = bus.in_a;
        b_src     = b_eff;
        sum_new   = seg_sum;
      end
    end else begin : g_src_prev
      // Later stages take the registered state of the stage before.
      always_comb begin
        valid_src = g_mid[k-1].ctl_q.valid;
        carry_src = g_mid[k-1].ctl_q.carry;
        a_src     = g_mid[k-1].a_q;
        b_src     = g_mid[k-1].b_q;
        sum_new   = {seg_sum, g_mid[k-1].sum_q};
      end
    end

    rca_seg #(
      .SEG_W (SEG)
    ) u_seg (
      .a    (a_src[SEG-1:0]),
      .b    (b_src[SEG-1:0]),
      .cin  (carry_src),
      .s    (seg_sum),
      .cout (seg_cout)
    );

    // Valid follows the pipe on every advance; data only loads for real beats.
    always_comb begin
      ctl_d = ctl_q;
      sum_d = sum_q;
      a_d   = a_q;
      b_d   = b_q;
      if (advance) begin
        ctl_d.valid = valid_src;
        if (valid_src) begin
          ctl_d.carry = seg_cout;
          sum_d       = sum_new;
          a_d         = a_src[WIDTH-LO-1:SEG];
          b_d         = b_src[WIDTH-LO-1:SEG];
        end
      end
    end

    // Stage register; reset drops any in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctl_q <= '0;
        sum_q <= '0;
        a_q   <= '0;
        b_q   <= '0;
      end else begin
        ctl_q <= ctl_d;
        sum_q <= sum_d;
        a_q   <= a_d;
        b_q   <= b_d;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Final stage: top segment, sign extension and overflow, output register.
  // --------------------------------------------------------------------------
  logic             last_valid;
  logic             last_carry;
  logic [SEG-1:0]   last_a;
  logic [SEG-1:0]   last_b;
  logic [SEG-1:0]   last_seg_sum;
  logic             last_cout;
  logic [WIDTH-1:0] last_sum;
  logic             last_sign;

  if (STAGES == 1) begin : g_last_src_in
    // Single stage: one registered full-width add.
    always_comb begin
      last_valid = bus.in_valid;
      last_carry = bus.in_sub;
      last_a     = bus.in_a;
      last_b     = b_eff;
      last_sum   = last_seg_sum;
    end
  end else begin : g_last_src_prev
    // Top segment fed by the last intermediate stage.
    always_comb begin
      last_valid = g_mid[STAGES-2].ctl_q.valid;
      last_carry = g_mid[STAGES-2].ctl_q.carry;
      last_a     = g_mid[STAGES-2].a_q;
      last_b     = g_mid[STAGES-2].b_q;
      last_sum   = {last_seg_sum, g_mid[STAGES-2].sum_q};
    end
  end

  rca_seg #(
    .SEG_W (SEG)
  ) u_seg_last (
    .a    (last_a),
    .b    (last_b),
    .cin  (last_carry),
    .s    (last_seg_sum),
    .cout (last_cout)
  );

  // Extra result bit is the sum of the sign-extended operands, so the
  // WIDTH+1 result is exact even for the most-negative corner cases.
  assign last_sign = last_a[SEG-1] ^ last_b[SEG-1] ^ last_cout;

  // Output slot holds while stalled; loads result and flag on advance.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    if (advance) begin
      out_valid_d = last_valid;
      if (last_valid) begin
        out_sum_d = {last_sign, last_sum};
        out_ovf_d = last_sign ^ last_sum[WIDTH-1];
      end
    end
  end

  // Output register; reset clears valid and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_s_rca_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_s_rca_pipe
// Description : Directed self-checking bench for s_rca_pipe (WIDTH=24,
//               STAGES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s_rca_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  s_rca_pipe_if #(.WIDTH(24)) bus ();

  s_rca_pipe #(
    .WIDTH  (24),
    .STAGES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: {ovf, 25-bit exact a+/-b}.
  function automatic logic [25:0] model(input logic [23:0] a, input logic [23:0] b,
                                        input logic sub);
    logic [24:0] ae, be, r;
    ae = {a[23], a};
    be = {b[23], b};
    r  = sub ? (ae - be) : (ae + be);
    return {r[24] ^ r[23], r};
  endfunction

  // One isolated beat: checks accept, latency of exactly 4 edges, result.
  task automatic single(input string tag, input logic [23:0] a, input logic [23:0] b,
                        input logic sub, input logic [24:0] es, input logic eo);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_sub    = sub;
    #1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sum"},   32'(bus.out_sum),   32'(es));
    chk({tag, "_ovf"},   32'(bus.out_ovf),   32'(eo));
    @(negedge clk);
  endtask

  // Streamed beats with optional out_ready stall window; scoreboarded.
  task automatic stream(input int n, input int stall_at, input int stall_len,
                        output int last_rx, output int n_rx);
    logic [25:0] q[$];
    logic [23:0] pa, pb;
    logic        ps;
    int          sent;
    int          c;
    sent    = 0;
    c       = 0;
    n_rx    = 0;
    last_rx = -1;
    pa = 24'($urandom);
    pb = 24'($urandom);
    ps = 1'($urandom_range(0, 1));
    while (n_rx < n && c < n + 60) begin
      bus.out_ready = !(c >= stall_at && c < stall_at + stall_len);
      if (sent < n) begin
        bus.in_valid = 1'b1;
        bus.in_a     = pa;
        bus.in_b     = pb;
        bus.in_sub   = ps;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("stream_unexpected_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          chk("stream_result", 32'({bus.out_ovf, bus.out_sum}), 32'(q[0]));
          if (bus.out_ready) begin
            void'(q.pop_front());
            n_rx++;
            last_rx = c;
          end else begin
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
          end
        end
      end
      if (sent < n && bus.in_ready) begin
        q.push_back(model(pa, pb, ps));
        sent++;
        pa = 24'($urandom);
        pb = 24'($urandom);
        ps = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      c++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  int last_rx;
  int n_rx;
  int stale;

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_sum",   32'(bus.out_sum),   32'd0);
    chk("reset_out_ovf",   32'(bus.out_ovf),   32'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // Directed corner vectors
    single("add_max_plus1",  24'h7FFFFF, 24'h000001, 1'b0, 25'h0800000, 1'b1);
    single("add_min_min",    24'h800000, 24'h800000, 1'b0, 25'h1000000, 1'b1);
    single("add_m1_plus1",   24'hFFFFFF, 24'h000001, 1'b0, 25'h0000000, 1'b0);
    single("sub_0_min",      24'h000000, 24'h800000, 1'b1, 25'h0800000, 1'b1);
    single("sub_5_3",        24'h000005, 24'h000003, 1'b1, 25'h0000002, 1'b0);
    single("sub_3_5",        24'h000003, 24'h000005, 1'b1, 25'h1FFFFFE, 1'b0);

    // Back-to-back random beats, full throughput
    stream(100, -1, 0, last_rx, n_rx);
    chk("b2b_count",      32'(n_rx),    32'd100);
    chk("b2b_last_cycle", 32'(last_rx), 32'd103);

    // Six-cycle output stall mid-stream
    stream(20, 8, 6, last_rx, n_rx);
    chk("stall_count",      32'(n_rx),    32'd20);
    chk("stall_last_cycle", 32'(last_rx), 32'd29);

    // Reset with beats in flight
    bus.out_ready = 1'b1;
    bus.in_sub    = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 24'h123456;
    bus.in_b      = 24'h111111;
    @(negedge clk);
    bus.in_a      = 24'h000100;
    @(negedge clk);
    bus.in_a      = 24'h000200;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    @(negedge clk);
    chk("rst_pre_valid", 32'(bus.out_valid), 32'd1);
    chk("rst_pre_sum",   32'(bus.out_sum),   32'h0234567);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_async_sum",   32'(bus.out_sum),   32'd0);
    chk("rst_async_ovf",   32'(bus.out_ovf),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_in_ready", 32'(bus.in_ready), 32'd1);
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    chk("rst_no_stale", 32'(stale), 32'd0);
    single("post_rst", 24'h000010, 24'h000020, 1'b0, 25'h0000030, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
